// File: rtl/rmii_rx_framer.sv
// RMII receive framer: qualifies the 01..01/11 preamble, then emits payload dibits
// with a one-cycle done pulse at end of frame and err pulses on framing faults.
module rmii_rx_framer #(
    parameter int unsigned MIN_PREAMBLE_DIBITS = 8,
    parameter int unsigned MAX_DIBITS          = 6144
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       crs_dv,
    input  logic [1:0] rxd,
    output logic [1:0] out,
    output logic       outclk,
    output logic       done,
    output logic       err
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, WAIT_IDLE} state_t;

    localparam int unsigned   PW      = $clog2(MIN_PREAMBLE_DIBITS + 1);
    localparam int unsigned   CW      = $clog2(MAX_DIBITS + 1);
    localparam logic [PW-1:0] PRE_SAT = PW'(MIN_PREAMBLE_DIBITS);
    localparam logic [PW-1:0] PRE_ACC = PW'(MIN_PREAMBLE_DIBITS - 1);
    localparam logic [CW-1:0] DMAX    = CW'(MAX_DIBITS);

    state_t        state_q, state_d;
    logic          crs_q;
    logic [1:0]    rxd_q;
    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic [1:0]    pend_q, pend_d;
    logic          pend_crs_q, pend_crs_d;
    logic          pend_vld_q, pend_vld_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic          low_q, low_d;
    logic [1:0]    out_q, out_d;
    logic          outclk_q, outclk_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        pend_d     = pend_q;
        pend_crs_d = pend_crs_q;
        pend_vld_d = pend_vld_q;
        dcnt_d     = dcnt_q;
        low_d      = low_q;
        out_d      = out_q;
        outclk_d   = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (crs_q && rxd_q == 2'b01) begin
                    state_d   = PREAMBLE;
                    pre_cnt_d = PW'(1);
                end
            end
            PREAMBLE: begin
                if (!crs_q) begin
                    state_d = IDLE;
                end else if (rxd_q == 2'b01) begin
                    if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + PW'(1);
                end else if (rxd_q == 2'b11 && pre_cnt_q >= PRE_ACC) begin
                    state_d    = DATA;
                    dcnt_d     = '0;
                    pend_vld_d = 1'b0;
                end else begin
                    err_d   = 1'b1;
                    low_d   = 1'b0;
                    state_d = WAIT_IDLE;
                end
            end
            DATA: begin
                pend_d     = rxd_q;
                pend_crs_d = crs_q;
                pend_vld_d = 1'b1;
                // A pending dibit survives if carrier was seen on either side of it,
                // which tolerates CRS_DV toggling at end of carrier.
                if (pend_vld_q) begin
                    if (pend_crs_q || crs_q) begin
                        if (dcnt_q == DMAX) begin
                            done_d  = 1'b1;
                            err_d   = 1'b1;
                            low_d   = 1'b0;
                            state_d = WAIT_IDLE;
                        end else begin
                            out_d    = pend_q;
                            outclk_d = 1'b1;
                            dcnt_d   = dcnt_q + CW'(1);
                        end
                    end else begin
                        done_d  = 1'b1;
                        err_d   = (dcnt_q[1:0] != 2'b00);
                        state_d = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (crs_q) begin
                    low_d = 1'b0;
                end else if (low_q) begin
                    state_d = IDLE;
                end else begin
                    low_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            crs_q      <= 1'b0;
            rxd_q      <= '0;
            pre_cnt_q  <= '0;
            pend_q     <= '0;
            pend_crs_q <= 1'b0;
            pend_vld_q <= 1'b0;
            dcnt_q     <= '0;
            low_q      <= 1'b0;
            out_q      <= '0;
            outclk_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            crs_q      <= crs_dv;
            rxd_q      <= rxd;
            pre_cnt_q  <= pre_cnt_d;
            pend_q     <= pend_d;
            pend_crs_q <= pend_crs_d;
            pend_vld_q <= pend_vld_d;
            dcnt_q     <= dcnt_d;
            low_q      <= low_d;
            out_q      <= out_d;
            outclk_q   <= outclk_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign out    = out_q;
    assign outclk = outclk_q;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Bench for rmii_rx_framer: a frame-level model derives per-cycle expectations
// for two instances (default and MAX_DIBITS=8) driven by the same pin stream.
module tb_rmii_rx_framer;
    localparam int NMAX = 128;
    localparam int MINP = 8;
    localparam int MAXA = 6144;
    localparam int MAXB = 8;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       crs_dv = 1'b0;
    logic [1:0] rxd    = 2'b00;
    logic [1:0] out_a, out_b;
    logic       outclk_a, outclk_b, done_a, done_b, err_a, err_b;

    rmii_rx_framer #(.MIN_PREAMBLE_DIBITS(MINP), .MAX_DIBITS(MAXA)) dut_a (
        .clk(clk), .reset(reset), .crs_dv(crs_dv), .rxd(rxd),
        .out(out_a), .outclk(outclk_a), .done(done_a), .err(err_a)
    );

    rmii_rx_framer #(.MIN_PREAMBLE_DIBITS(MINP), .MAX_DIBITS(MAXB)) dut_b (
        .clk(clk), .reset(reset), .crs_dv(crs_dv), .rxd(rxd),
        .out(out_b), .outclk(outclk_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    bit         s_crs [NMAX];
    logic [1:0] s_rxd [NMAX];
    int         n;

    bit         e_oc   [2][NMAX];
    logic [1:0] e_out  [2][NMAX];
    bit         e_done [2][NMAX];
    bit         e_err  [2][NMAX];

    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;
    bit    chk_en = 1'b0;
    string seg_tag = "init";
    int    n_oc [2];
    int    n_done [2];
    int    n_err [2];
    int    first_oc, first_done;

    task automatic cmp(input string nm, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s_%s cycle %0d: got {out,outclk,done,err}=%b, required %b",
                     seg_tag, nm, cyc, act, exp);
        end
    endtask

    task automatic cmpi(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s_%s: got %0d, required %0d", seg_tag, nm, act, exp);
        end
    endtask

    task automatic put(input bit c, input logic [1:0] r);
        if (n < NMAX - 4) begin
            s_crs[n] = c;
            s_rxd[n] = r;
            n++;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) put(1'b0, 2'b00);
    endtask

    task automatic pre(input int k);
        repeat (k) put(1'b1, 2'b01);
        put(1'b1, 2'b11);
    endtask

    task automatic put_byte(input logic [7:0] b);
        put(1'b1, b[1:0]);
        put(1'b1, b[3:2]);
        put(1'b1, b[5:4]);
        put(1'b1, b[7:6]);
    endtask

    // First pin index at which the receiver is idle again after two low carrier samples.
    function automatic int wait_idle(input int w);
        for (int j = w; j + 1 < n; j++)
            if (!s_crs[j] && !s_crs[j+1]) return j + 2;
        return n;
    endfunction

    // Frame-level model: a decision taken on pin sample m is visible at cycle m+2;
    // a payload dibit at pin index i appears on out at cycle i+3.
    task automatic build_model(input int d, input int maxd);
        int         m, cnt, i;
        logic [1:0] last;
        for (int k = 0; k < NMAX; k++) begin
            e_oc[d][k]   = 1'b0;
            e_done[d][k] = 1'b0;
            e_err[d][k]  = 1'b0;
            e_out[d][k]  = 2'b00;
        end
        m = 0;
        while (m < n) begin
            if (!(s_crs[m] && s_rxd[m] == 2'b01)) begin
                m++;
                continue;
            end
            cnt = 1;
            m++;
            while (m < n && s_crs[m] && s_rxd[m] == 2'b01) begin
                if (cnt < MINP) cnt++;
                m++;
            end
            if (m >= n) break;
            if (!s_crs[m]) begin
                m++;
            end else if (s_rxd[m] == 2'b11 && cnt >= MINP - 1) begin
                cnt = 0;
                i = m + 1;
                m = n;
                while (i + 1 < n) begin
                    if (!s_crs[i] && !s_crs[i+1]) begin
                        e_done[d][i+3] = 1'b1;
                        e_err[d][i+3]  = (cnt % 4 != 0);
                        m = i + 2;
                        break;
                    end
                    if (cnt == maxd) begin
                        e_done[d][i+3] = 1'b1;
                        e_err[d][i+3]  = 1'b1;
                        m = wait_idle(i + 2);
                        break;
                    end
                    e_oc[d][i+3]  = 1'b1;
                    e_out[d][i+3] = s_rxd[i];
                    cnt++;
                    i++;
                end
            end else begin
                e_err[d][m+2] = 1'b1;
                m = wait_idle(m + 1);
            end
        end
        last = 2'b00;
        for (int k = 0; k < NMAX; k++) begin
            if (e_oc[d][k]) last = e_out[d][k];
            else            e_out[d][k] = last;
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            cmp("reset_a", {out_a, outclk_a, done_a, err_a}, 5'b0);
            cmp("reset_b", {out_b, outclk_b, done_b, err_b}, 5'b0);
        end else if (chk_en) begin
            cmp("cyc_a", {out_a, outclk_a, done_a, err_a},
                {e_out[0][cyc], e_oc[0][cyc], e_done[0][cyc], e_err[0][cyc]});
            cmp("cyc_b", {out_b, outclk_b, done_b, err_b},
                {e_out[1][cyc], e_oc[1][cyc], e_done[1][cyc], e_err[1][cyc]});
            n_oc[0]   += int'(outclk_a);
            n_done[0] += int'(done_a);
            n_err[0]  += int'(err_a);
            n_oc[1]   += int'(outclk_b);
            n_done[1] += int'(done_b);
            n_err[1]  += int'(err_b);
            if (outclk_a && first_oc < 0) first_oc = cyc;
            if (done_a && first_done < 0) first_done = cyc;
        end
    end

    task automatic run_segment(input string tag, input int oa, input int da, input int ea,
                               input int ob, input int db, input int eb,
                               input logic rc, input logic [1:0] rr);
        build_model(0, MAXA);
        build_model(1, MAXB);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        crs_dv = rc;
        rxd    = rr;
        chk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        seg_tag = tag;
        for (int d = 0; d < 2; d++) begin
            n_oc[d]   = 0;
            n_done[d] = 0;
            n_err[d]  = 0;
        end
        first_oc   = -1;
        first_done = -1;
        reset  = 1'b0;
        cyc    = 0;
        crs_dv = s_crs[0];
        rxd    = s_rxd[0];
        chk_en = 1'b1;
        for (int k = 1; k < n; k++) begin
            @(posedge clk);
            #1;
            cyc    = k;
            crs_dv = s_crs[k];
            rxd    = s_rxd[k];
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        cmpi("strobes_a", n_oc[0], oa);
        cmpi("dones_a", n_done[0], da);
        cmpi("errs_a", n_err[0], ea);
        cmpi("strobes_b", n_oc[1], ob);
        cmpi("dones_b", n_done[1], db);
        cmpi("errs_b", n_err[1], eb);
    endtask

    initial begin
        // 7x01 + SFD + 0xD5 (dibits 01,01,01,11), carrier drops
        n = 0;
        idle(3); pre(7); put_byte(8'hD5); idle(6);
        run_segment("d5", 4, 1, 0, 4, 1, 0, 1'b0, 2'b00);
        cmpi("first_out_cycle", first_oc, 14);
        cmpi("done_cycle", first_done, 18);

        // end-of-carrier toggling over the last four dibits
        n = 0;
        idle(2); pre(7); put_byte(8'h1B);
        put(1'b0, 2'b10); put(1'b1, 2'b01); put(1'b0, 2'b11); put(1'b1, 2'b00);
        idle(6);
        run_segment("toggle", 8, 1, 0, 8, 1, 0, 1'b0, 2'b00);

        // short preamble, bad preamble dibit, carrier loss during preamble
        n = 0;
        idle(2); pre(3);
        put(1'b1, 2'b01); put(1'b1, 2'b01); put(1'b0, 2'b00);
        put(1'b1, 2'b01); put(1'b1, 2'b01); put(1'b1, 2'b01); put(1'b1, 2'b11);
        idle(4);
        repeat (7) put(1'b1, 2'b01);
        put(1'b1, 2'b00); idle(2);
        repeat (5) put(1'b1, 2'b01);
        idle(6);
        run_segment("badpre", 0, 0, 2, 0, 0, 2, 1'b0, 2'b00);

        // 6-dibit partial-byte frame followed back-to-back by a good frame
        n = 0;
        idle(2); pre(8); put_byte(8'h3C); put(1'b1, 2'b01); put(1'b1, 2'b10);
        idle(2); pre(7); put_byte(8'hA5); idle(6);
        run_segment("partial", 10, 2, 1, 10, 2, 1, 1'b0, 2'b00);

        // 12-dibit frame: overflows only the MAX_DIBITS=8 instance
        n = 0;
        idle(2); pre(7); put_byte(8'h12); put_byte(8'h34); put_byte(8'h56);
        idle(2); pre(7); put_byte(8'h9A); idle(6);
        run_segment("maxlen", 16, 2, 0, 12, 2, 1, 1'b0, 2'b00);

        // frame interrupted by reset after two emitted dibits
        n = 0;
        idle(2); pre(7);
        put(1'b1, 2'b01); put(1'b1, 2'b10); put(1'b1, 2'b11); put(1'b1, 2'b00); put(1'b1, 2'b01);
        run_segment("prereset", 2, 0, 0, 2, 0, 0, 1'b0, 2'b00);

        // pins keep carrying the aborted frame through and after reset
        n = 0;
        put(1'b1, 2'b10); put(1'b1, 2'b00); put(1'b1, 2'b11);
        put(1'b1, 2'b10); put(1'b1, 2'b00); put(1'b1, 2'b11);
        idle(2); pre(7);
        put(1'b1, 2'b01); put(1'b1, 2'b10); put(1'b1, 2'b00); put(1'b1, 2'b11);
        idle(6);
        run_segment("postreset", 4, 1, 0, 4, 1, 0, 1'b1, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
